// File: rtl/drac_l15_req_arbiter_if.sv
// Request/return bundle between the cache-side requesters, the L1.5 request channel and
// drac_l15_req_arbiter. The slave modport is the arbiter's view; master drives the other side.
interface drac_l15_req_arbiter_if #(
  parameter int NumPorts = 6,
  parameter int ReqWidth = 128,
  parameter int PW       = (NumPorts > 1) ? $clog2(NumPorts) : 1
);
  logic [NumPorts-1:0]          req_valid_i;
  logic [NumPorts-1:0]          req_ready_o;
  logic [NumPorts*ReqWidth-1:0] req_data_i;
  logic                         l15_val_o;
  logic [ReqWidth-1:0]          l15_data_o;
  logic [PW-1:0]                l15_portid_o;
  logic                         l15_ack_i;
  logic                         rtrn_valid_i;
  logic [PW-1:0]                rtrn_portid_i;
  logic [NumPorts-1:0]          port_full_o;
  logic                         err_o;

  modport slave (
    input  req_valid_i, req_data_i, l15_ack_i, rtrn_valid_i, rtrn_portid_i,
    output req_ready_o, l15_val_o, l15_data_o, l15_portid_o, port_full_o, err_o
  );

  modport master (
    output req_valid_i, req_data_i, l15_ack_i, rtrn_valid_i, rtrn_portid_i,
    input  req_ready_o, l15_val_o, l15_data_o, l15_portid_o, port_full_o, err_o
  );
endinterface

// File: rtl/drac_l15_req_arbiter.sv
// N-port priority arbiter towards the L1.5 request channel with per-port outstanding tracking.
// Define DRAC_L15_ARB_STARVE_EN to add per-port wait counters and starvation promotion.
module drac_l15_req_arbiter #(
  parameter int NumPorts       = 6,
  parameter int ReqWidth       = 128,
  parameter int MaxOutstanding = 4,
  parameter int StarveTh       = 16,
  localparam int PW            = (NumPorts > 1) ? $clog2(NumPorts) : 1,
  localparam int CW            = $clog2(MaxOutstanding + 1)
) (
  input logic                   clk_i,
  input logic                   rst_ni,
  drac_l15_req_arbiter_if.slave bus
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t              state_reg;
  logic                val_reg;
  logic                err_reg;
  logic [ReqWidth-1:0] data_reg;
  logic [PW-1:0]       portid_reg;
  logic [CW-1:0]       cnt_reg  [NumPorts];
  logic [CW-1:0]       cnt_next [NumPorts];
  logic [ReqWidth-1:0] slice    [NumPorts];

  logic [NumPorts-1:0] full;
  logic [NumPorts-1:0] zero;
  logic [NumPorts-1:0] eligible;
  logic [NumPorts-1:0] promoted;
  logic [NumPorts-1:0] cand;
  logic [NumPorts-1:0] grant;
  logic [NumPorts-1:0] rtrn_hit;
  logic [NumPorts-1:0] ack_hit;
  logic [ReqWidth-1:0] data_next;
  logic [PW-1:0]       win_idx;
  logic                handshake;
  logic                rtrn_bad_id;
  logic                err_next;

  generate
    for (genvar gi = 0; gi < NumPorts; gi++) begin : g_port
      assign slice[gi]    = bus.req_data_i[gi*ReqWidth +: ReqWidth];
      assign full[gi]     = (cnt_reg[gi] == CW'(MaxOutstanding));
      assign zero[gi]     = (cnt_reg[gi] == '0);
      assign rtrn_hit[gi] = bus.rtrn_valid_i && (bus.rtrn_portid_i == PW'(gi));
      assign ack_hit[gi]  = (state_reg == HOLD) && bus.l15_ack_i && (portid_reg == PW'(gi));
      // An ack and a return on the same port cancel; a return to an empty port is an error, not an underflow.
      assign cnt_next[gi] = (ack_hit[gi] && rtrn_hit[gi])   ? cnt_reg[gi] :
                            ack_hit[gi]                     ? cnt_reg[gi] + CW'(1) :
                            (rtrn_hit[gi] && !zero[gi])     ? cnt_reg[gi] - CW'(1) :
                                                              cnt_reg[gi];
    end
  endgenerate

  assign eligible  = bus.req_valid_i & ~full;
  assign cand      = (|(eligible & promoted)) ? (eligible & promoted) : eligible;
  assign grant     = cand & (~cand + NumPorts'(1));
  assign handshake = (state_reg == IDLE) && (|cand);

  always_comb begin
    win_idx   = '0;
    data_next = '0;
    for (int k = 0; k < NumPorts; k++) begin
      if (grant[k]) begin
        win_idx   = PW'(k);
        data_next = slice[k];
      end
    end
  end

  assign rtrn_bad_id = bus.rtrn_valid_i && (int'(bus.rtrn_portid_i) >= NumPorts);
  assign err_next    = err_reg || rtrn_bad_id || (|(rtrn_hit & zero));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg  <= IDLE;
      val_reg    <= 1'b0;
      data_reg   <= '0;
      portid_reg <= '0;
      err_reg    <= 1'b0;
      for (int k = 0; k < NumPorts; k++) cnt_reg[k] <= '0;
    end else begin
      err_reg <= err_next;
      for (int k = 0; k < NumPorts; k++) cnt_reg[k] <= cnt_next[k];
      case (state_reg)
        IDLE: begin
          if (handshake) begin
            state_reg  <= HOLD;
            val_reg    <= 1'b1;
            data_reg   <= data_next;
            portid_reg <= win_idx;
          end
        end
        HOLD: begin
          if (bus.l15_ack_i) begin
            state_reg <= IDLE;
            val_reg   <= 1'b0;
          end
        end
        default: begin
          state_reg <= IDLE;
          val_reg   <= 1'b0;
        end
      endcase
    end
  end

`ifdef DRAC_L15_ARB_STARVE_EN
  localparam int WW = $clog2(StarveTh + 1);

  logic [WW-1:0] wait_cnt_reg  [NumPorts];
  logic [WW-1:0] wait_cnt_next [NumPorts];

  generate
    for (genvar gi = 0; gi < NumPorts; gi++) begin : g_starve
      assign promoted[gi] = (wait_cnt_reg[gi] == WW'(StarveTh));
      // Losing while eligible in IDLE ages the port; winning or dropping valid starts it over.
      assign wait_cnt_next[gi] =
        (!bus.req_valid_i[gi] || (handshake && grant[gi])) ? '0 :
        ((state_reg == IDLE) && eligible[gi] && !promoted[gi]) ? wait_cnt_reg[gi] + WW'(1) :
        wait_cnt_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < NumPorts; k++) wait_cnt_reg[k] <= '0;
    end else begin
      for (int k = 0; k < NumPorts; k++) wait_cnt_reg[k] <= wait_cnt_next[k];
    end
  end
`else
  logic unused_starve_th;
  assign unused_starve_th = ^StarveTh;
  assign promoted         = '0;
`endif

  assign bus.req_ready_o  = (state_reg == IDLE) ? grant : '0;
  assign bus.l15_val_o    = val_reg;
  assign bus.l15_data_o   = data_reg;
  assign bus.l15_portid_o = portid_reg;
  assign bus.port_full_o  = full;
  assign bus.err_o        = err_reg;

endmodule
